// File: rtl/float32_pkg.sv
// float32_pkg: shared single-precision float definitions.
// Used by the int-to-float converter and the float-to-int stage so that both
// agree on field widths, exponent bias and the field slice/pack helpers.
package float32_pkg;

    localparam int FLOAT_BIAS = 127;
    localparam int EXP_W      = 8;
    localparam int FRAC_W     = 23;

    // Canonical zero result; negative zero is never produced.
    localparam logic [31:0] FLOAT_POS_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float32_t;

    function automatic logic [31:0] float_pack(input logic              sign,
                                               input logic [EXP_W-1:0]  exp,
                                               input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

    function automatic logic float_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [EXP_W-1:0] float_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [FRAC_W-1:0] float_frac(input logic [31:0] f);
        return f[22:0];
    endfunction

endpackage

// File: rtl/lzc32.sv
// lzc32: combinational 32-bit leading-zero counter.
// Ports:
//   a     - value to scan
//   count - number of zeros above the most significant set bit (0..31);
//           0 when a is all zero
//   zero  - a is all zero
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  count,
    output logic        zero
);

    // first_one[gi] is set only for the most significant set bit of a.
    logic [31:0] first_one;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_scan
            assign first_one[gi] = a[gi] & ~(|(a >> (gi + 1)));
        end
    endgenerate

    // first_one is one-hot (or zero), so OR-ing the encoded positions is exact.
    always_comb begin
        count = '0;
        for (int i = 0; i < 32; i++) begin
            if (first_one[i]) begin
                count = count | 5'(31 - i);
            end
        end
    end

    assign zero = ~(|a);

endmodule

// File: rtl/to_float.sv
// to_float: 3-stage pipelined 32-bit integer to float32 converter,
// round-to-nearest ties-to-even, with valid/ready flow control.
// Parameters:
//   SIGNED_IN - 1: in_a is two's complement, 0: in_a is unsigned
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   in_a      - integer operand, in_valid/in_ready handshake
//   out_z     - float32 result, out_valid/out_ready handshake
// Stages: S1 sign/magnitude, S2 normalise, S3 round and pack (output register).
module to_float
    import float32_pkg::*;
#(
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_z,
    output logic        out_valid,
    input  logic        out_ready
);

    // Stage S1: sign / magnitude
    logic        s1_valid;
    logic        s1_sign;
    logic [31:0] s1_mag;
    logic        s1_zero;

    // Stage S2: normalised mantissa (hidden one dropped) and biased exponent
    logic             s2_valid;
    logic             s2_sign;
    logic             s2_zero;
    logic [EXP_W-1:0] s2_exp;
    logic [30:0]      s2_norm;

    // Stage S3: packed result
    logic        s3_valid;

    // Each stage loads when empty or when the stage after it loads, so a
    // bubble anywhere in the pipe is squeezed out even under back-pressure.
    logic s1_load;
    logic s2_load;
    logic s3_load;

    assign s3_load  = ~s3_valid | out_ready;
    assign s2_load  = ~s2_valid | s3_load;
    assign s1_load  = ~s1_valid | s2_load;
    assign in_ready = s1_load;

    assign out_valid = s3_valid;

    // S1 combinational: 0x80000000 negates to itself, which is the correct
    // unsigned magnitude 2^31.
    logic        in_sign;
    logic [31:0] in_mag;

    assign in_sign = SIGNED_IN & in_a[31];
    assign in_mag  = in_sign ? (~in_a + 32'd1) : in_a;

    // S2 combinational
    logic [4:0]       lz;
    logic             lz_zero;
    logic [30:0]      norm_low;
    logic [EXP_W-1:0] norm_exp;

    lzc32 u_lzc (
        .a     (s1_mag),
        .count (lz),
        .zero  (lz_zero)
    );

    // Bit 31 of the shifted value is the hidden one, so only 30:0 is kept.
    assign norm_low = 31'(s1_mag << lz);
    assign norm_exp = EXP_W'(FLOAT_BIAS + 31) - {3'b000, lz};

    // S3 combinational: round to nearest, ties to even
    logic [FRAC_W-1:0] frac_trunc;
    logic              guard_bit;
    logic              sticky_bit;
    logic              round_up;
    logic [FRAC_W:0]   frac_sum;
    logic [FRAC_W-1:0] frac_rnd;
    logic [EXP_W-1:0]  exp_rnd;
    logic [31:0]       result;

    assign frac_trunc = s2_norm[30:8];
    assign guard_bit  = s2_norm[7];
    assign sticky_bit = |s2_norm[6:0];
    assign round_up   = guard_bit & (sticky_bit | frac_trunc[0]);
    assign frac_sum   = {1'b0, frac_trunc} + {{FRAC_W{1'b0}}, round_up};

    // A carry out of the fraction means the mantissa rolled over to 2.0:
    // fraction wraps to zero (frac_sum[22:0] already is) and exponent steps up.
    assign frac_rnd = frac_sum[FRAC_W-1:0];
    assign exp_rnd  = s2_exp + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
    assign result   = s2_zero ? FLOAT_POS_ZERO : float_pack(s2_sign, exp_rnd, frac_rnd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mag   <= '0;
            s1_zero  <= 1'b0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_zero  <= 1'b0;
            s2_exp   <= '0;
            s2_norm  <= '0;
            s3_valid <= 1'b0;
            out_z    <= FLOAT_POS_ZERO;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_sign;
                    s1_mag  <= in_mag;
                    s1_zero <= (in_a == 32'd0);
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sign <= s1_sign;
                    s2_zero <= s1_zero | lz_zero;
                    s2_exp  <= norm_exp;
                    s2_norm <= norm_low;
                end
            end
            // out_z only changes when a real item moves in, so it holds
            // steady while stalled and after the last item leaves.
            if (s3_load) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    out_z <= result;
                end
            end
        end
    end

endmodule

// File: tb/tb_to_float.sv
// tb_to_float: scoreboard bench for to_float, one signed and one unsigned
// instance. Drivers push expected results when a transfer is accepted;
// monitors pop and compare when an output transfer occurs.
module tb_to_float;

    logic        clk;
    logic        rst;

    logic [31:0] s_a;
    logic        s_v;
    logic        s_rdy;
    logic [31:0] s_z;
    logic        s_ov;
    logic        s_ordy;

    logic [31:0] u_a;
    logic        u_v;
    logic        u_rdy;
    logic [31:0] u_z;
    logic        u_ov;
    logic        u_ordy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit lat_chk = 0;
    bit bp_mode = 0;

    logic [31:0] exp_s[$];
    int          cyc_s[$];
    logic [31:0] exp_u[$];

    to_float #(.SIGNED_IN(1'b1)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_a      (s_a),
        .in_valid  (s_v),
        .in_ready  (s_rdy),
        .out_z     (s_z),
        .out_valid (s_ov),
        .out_ready (s_ordy)
    );

    to_float #(.SIGNED_IN(1'b0)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .in_a      (u_a),
        .in_valid  (u_v),
        .in_ready  (u_rdy),
        .out_z     (u_z),
        .out_valid (u_ov),
        .out_ready (u_ordy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact magnitude, then round to a 24-bit significand by
    // integer quotient/remainder against half an ulp.
    function automatic logic [31:0] model(input logic [31:0] a, input bit sgn);
        logic [63:0] mag, q, r, half;
        int          e, sh;
        logic        s;
        s   = sgn & a[31];
        mag = s ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        if (mag == 64'd0) return 32'h0;
        e = 0;
        while ((mag >> (e + 1)) != 64'd0) e++;
        if (e <= 23) begin
            q = mag << (23 - e);
        end else begin
            sh   = e - 23;
            q    = mag >> sh;
            r    = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (r > half || (r == half && q[0])) q = q + 64'd1;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                e++;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_s(input logic [31:0] a, input logic [31:0] expv);
        s_a = a;
        s_v = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (s_rdy) begin
                exp_s.push_back(expv);
                cyc_s.push_back(cyc);
                @(posedge clk);
                #1;
                s_v = 1'b0;
                return;
            end
            if (t >= 200) begin
                errors++;
                $display("FAIL send_s_timeout got in_ready=0 exp in_ready=1 a=%h", a);
                s_v = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_u(input logic [31:0] a, input logic [31:0] expv);
        u_a = a;
        u_v = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (u_rdy) begin
                exp_u.push_back(expv);
                @(posedge clk);
                #1;
                u_v = 1'b0;
                return;
            end
            if (t >= 200) begin
                errors++;
                $display("FAIL send_u_timeout got in_ready=0 exp in_ready=1 a=%h", a);
                u_v = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500; t++) begin
            if (exp_s.size() == 0 && exp_u.size() == 0) return;
            @(posedge clk);
            #1;
        end
        errors++;
        $display("FAIL drain_timeout got pending=%0d/%0d exp pending=0/0", exp_s.size(), exp_u.size());
    endtask

    // Monitor for the signed instance: results, order, hold, in_ready rule, latency.
    initial begin
        int          inflight_s = 0;
        bit          hold_s     = 0;
        logic [31:0] held_z_s   = '0;
        logic [31:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight_s = 0;
                hold_s     = 0;
            end else begin
                if (hold_s) begin
                    checks++;
                    if (!s_ov || s_z !== held_z_s) begin
                        errors++;
                        $display("FAIL hold_stable got valid=%0b z=%h exp valid=1 z=%h", s_ov, s_z, held_z_s);
                    end
                end
                if (!s_rdy) begin
                    checks++;
                    if (!(s_ov && !s_ordy && inflight_s == 3)) begin
                        errors++;
                        $display("FAIL in_ready_low got inflight=%0d out_ready=%0b exp inflight=3 out_ready=0", inflight_s, s_ordy);
                    end
                end
                if (s_ov && s_ordy) begin
                    checks++;
                    if (exp_s.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out_s got %h exp none", s_z);
                    end else begin
                        e = exp_s.pop_front();
                        c = cyc_s.pop_front();
                        if (s_z !== e) begin
                            errors++;
                            $display("FAIL result_s got %h exp %h", s_z, e);
                        end
                        if (lat_chk) begin
                            checks++;
                            if (cyc - c != 3) begin
                                errors++;
                                $display("FAIL latency got %0d exp 3", cyc - c);
                            end
                        end
                    end
                end
                inflight_s = inflight_s + int'(s_v && s_rdy) - int'(s_ov && s_ordy);
                hold_s     = s_ov && !s_ordy;
                held_z_s   = s_z;
            end
        end
    end

    // Monitor for the unsigned instance.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && u_ov && u_ordy) begin
                checks++;
                if (exp_u.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out_u got %h exp none", u_z);
                end else begin
                    e = exp_u.pop_front();
                    if (u_z !== e) begin
                        errors++;
                        $display("FAIL result_u got %h exp %h", u_z, e);
                    end
                end
            end
        end
    end

    // Random out_ready for the signed instance while back-pressure is on.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) s_ordy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        rst    = 1'b1;
        s_a    = '0;
        s_v    = 1'b0;
        s_ordy = 1'b1;
        u_a    = '0;
        u_v    = 1'b0;
        u_ordy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ov !== 1'b0 || s_z !== 32'h0 || u_ov !== 1'b0 || u_z !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got ov=%0b z=%h uov=%0b uz=%h exp 0/0", s_ov, s_z, u_ov, u_z);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_rdy !== 1'b1 || u_rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %0b/%0b exp 1/1", s_rdy, u_rdy);
        end
        @(posedge clk);
        #1;

        // Directed values, back-to-back, latency checked.
        lat_chk = 1;
        fork
            begin
                send_s(32'h0000_0001, 32'h3F80_0000);
                send_s(32'hFFFF_FFFF, 32'hBF80_0000);
                send_s(32'h0000_0000, 32'h0000_0000);
                send_s(32'h8000_0000, 32'hCF00_0000);
                send_s(32'h0100_0001, 32'h4B80_0000);
                send_s(32'h0100_0003, 32'h4B80_0002);
                send_s(32'h7FFF_FFFF, 32'h4F00_0000);
                send_s(32'h0100_0000, 32'h4B80_0000);
            end
            begin
                send_u(32'hFFFF_FFFF, 32'h4F80_0000);
                send_u(32'h8000_0000, 32'h4F00_0000);
                send_u(32'h0000_0000, 32'h0000_0000);
                send_u(32'h0000_0005, 32'h40A0_0000);
            end
        join
        drain();
        lat_chk = 0;

        // Back-pressure: ascending stream with random out_ready.
        bp_mode = 1;
        for (int i = 0; i < 10; i++) begin
            v = 32'(i - 3);
            send_s(v, model(v, 1'b1));
        end
        drain();
        bp_mode = 0;
        s_ordy  = 1'b1;
        @(posedge clk);
        #1;

        // Reset with three items in flight.
        s_ordy = 1'b0;
        send_s(32'd11, model(32'd11, 1'b1));
        send_s(32'd12, model(32'd12, 1'b1));
        send_s(32'd13, model(32'd13, 1'b1));
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (s_ov !== 1'b0 || s_z !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got ov=%0b z=%h exp ov=0 z=00000000", s_ov, s_z);
        end
        exp_s.delete();
        cyc_s.delete();
        @(posedge clk);
        #1;
        rst    = 1'b0;
        s_ordy = 1'b1;
        lat_chk = 1;
        send_s(32'd5, 32'h40A0_0000);
        drain();
        lat_chk = 0;

        // Random sweep, with back-pressure over the first part.
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if (i == 0) bp_mode = 1;
                    if (i == 2000) begin
                        bp_mode = 0;
                        s_ordy  = 1'b1;
                    end
                    v = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
                    send_s(v, model(v, 1'b1));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    v = $urandom >> $urandom_range(0, 31);
                    send_u(v, model(v, 1'b0));
                end
            end
        join
        bp_mode = 0;
        s_ordy  = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
